// File: rtl/seg2bin_scanner.sv
// seg2bin_scanner: read-back monitor for a time-multiplexed, active-low seven-segment bus.
// Each digit is captured once its pattern has settled, then complete frames are published.
module seg2bin_scanner #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [0:6]          SEV,
    input  logic [DIGITS-1:0]   AN,
    output logic [4*DIGITS-1:0] BIN_OUT,
    output logic [DIGITS-1:0]   DIGIT_ERR,
    output logic                VALID,
    output logic                FRAME_VALID
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef struct packed {
        logic       err;
        logic [3:0] val;
    } cap_t;

    typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;

    logic [0:6]              sev_q, sev_p;
    logic [DIGITS-1:0]       an_q, an_p;
    state_t                  state, state_n;
    logic [CW-1:0]           cnt, cnt_n;
    logic                    capture, same, onehot, publish;
    logic [IW-1:0]           slot;
    cap_t                    cap;
    logic [DIGITS-1:0]       seen;
    cap_t [DIGITS-1:0]       shadow;

    function automatic cap_t decode(input logic [0:6] p);
        cap_t c;
        c.err = 1'b0;
        case (p)
            7'b0000001: c.val = 4'h0;
            7'b1001111: c.val = 4'h1;
            7'b0010010: c.val = 4'h2;
            7'b0000110: c.val = 4'h3;
            7'b1001100: c.val = 4'h4;
            7'b0100100: c.val = 4'h5;
            7'b0100000: c.val = 4'h6;
            7'b0001111: c.val = 4'h7;
            7'b0000000: c.val = 4'h8;
            7'b0001100: c.val = 4'h9;
            7'b0001000: c.val = 4'hA;
            7'b1100000: c.val = 4'hB;
            7'b0110001: c.val = 4'hC;
            7'b1000010: c.val = 4'hD;
            7'b0110000: c.val = 4'hE;
            7'b0111000: c.val = 4'hF;
            default: begin
                c.val = 4'h0;
                c.err = 1'b1;
            end
        endcase
        return c;
    endfunction

    assign cap     = decode(sev_q);
    assign same    = (sev_q == sev_p) && (an_q == an_p);
    assign onehot  = ($countones(~an_q) == 1);
    assign publish = &seen;

    always_comb begin
        slot = '0;
        for (int i = 0; i < DIGITS; i++)
            if (!an_q[i]) slot = IW'(i);
    end

    // One capture per dwell: HOLD waits for the pair to change before re-arming.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        capture = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (onehot) begin
                    state_n = TRACK;
                    cnt_n   = CW'(1);
                end
            end
            TRACK: begin
                if (!onehot) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (!same) begin
                    cnt_n = CW'(1);
                end else if (cnt >= CW'(STABLE_CYCLES - 1)) begin
                    capture = 1'b1;
                    state_n = HOLD;
                    cnt_n   = CW'(STABLE_CYCLES);
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            HOLD: begin
                if (!same) begin
                    if (onehot) begin
                        state_n = TRACK;
                        cnt_n   = CW'(1);
                    end else begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sev_q       <= '1;
            an_q        <= '1;
            sev_p       <= '1;
            an_p        <= '1;
            state       <= IDLE;
            cnt         <= '0;
            FRAME_VALID <= 1'b0;
            VALID       <= 1'b0;
        end else begin
            sev_q       <= SEV;
            an_q        <= AN;
            sev_p       <= sev_q;
            an_p        <= an_q;
            state       <= state_n;
            cnt         <= cnt_n;
            FRAME_VALID <= publish;
            VALID       <= VALID | publish;
        end
    end

    // Per-digit shadow, seen flag and published copy; a capture on the publish edge survives the clear.
    for (genvar i = 0; i < DIGITS; i++) begin : g_lane
        logic wr, sn;
        cap_t sh, pub;

        assign wr = capture && (slot == IW'(i));

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sh  <= '0;
                sn  <= 1'b0;
                pub <= '0;
            end else begin
                if (wr) sh <= cap;
                sn <= wr | (sn & ~publish);
                if (publish) pub <= sh;
            end
        end

        assign shadow[i]          = sh;
        assign seen[i]            = sn;
        assign BIN_OUT[4*i +: 4]  = pub.val;
        assign DIGIT_ERR[i]       = pub.err;
    end

endmodule

// File: tb/tb_seg2bin_scanner.sv
// Bench for seg2bin_scanner: run-length model of the sampled bus checked every cycle,
// plus directed scans with hand-computed frame values and publish latency.
module tb_seg2bin_scanner;
    localparam int DIGITS = 4;
    localparam int S      = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic [0:6]          sev;
    logic [DIGITS-1:0]   an;
    logic [4*DIGITS-1:0] bin_out;
    logic [DIGITS-1:0]   digit_err;
    logic                valid, frame_valid;

    int checks = 0, failures = 0, fv_count = 0, base = 0;

    logic [6:0] glyph [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    seg2bin_scanner #(.DIGITS(DIGITS), .STABLE_CYCLES(S)) dut (
        .clk(clk), .reset(reset), .SEV(sev), .AN(an),
        .BIN_OUT(bin_out), .DIGIT_ERR(digit_err), .VALID(valid), .FRAME_VALID(frame_valid));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // v >= 16 shows a blank digit
    task automatic show(input int d, input int v, input int n);
        an    = '1;
        an[d] = 1'b0;
        sev   = (v < 16) ? glyph[v] : 7'h7f;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        an  = '1;
        sev = '1;
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [4:0] decode(input logic [6:0] p);
        for (int i = 0; i < 16; i++)
            if (glyph[i] == p) return {1'b0, 4'(i)};
        return 5'b10000;
    endfunction

    // Model: a digit is captured once S identical one-hot samples have been registered, once per run.
    logic [DIGITS-1:0]   m_an, e_err, m_seen, sh_err;
    logic [6:0]          m_sev;
    logic [4*DIGITS-1:0] e_bin, sh_val;
    logic                e_vld, e_fv, m_done;
    int                  m_run;

    always begin
        @(posedge clk or posedge reset);
        if (reset) begin
            m_an = '1; m_sev = '1; m_run = 0; m_done = 1'b0; m_seen = '0;
            sh_val = '0; sh_err = '0; e_bin = '0; e_err = '0; e_vld = 1'b0; e_fv = 1'b0;
        end else begin
            e_fv = 1'b0;
            if (m_seen == '1) begin
                e_bin = sh_val; e_err = sh_err; e_fv = 1'b1; e_vld = 1'b1; m_seen = '0;
            end
            if ($countones(~m_an) == 1 && m_run >= S && !m_done) begin
                for (int i = 0; i < DIGITS; i++)
                    if (!m_an[i]) begin
                        logic [4:0] r;
                        r = decode(m_sev);
                        sh_val[4*i +: 4] = r[3:0];
                        sh_err[i] = r[4];
                        m_seen[i] = 1'b1;
                    end
                m_done = 1'b1;
            end
            if (an == m_an && sev == m_sev) begin
                if (m_run < 1000) m_run++;
            end else begin
                m_run = 1; m_done = 1'b0;
            end
            m_an = an; m_sev = sev;
        end
    end

    always begin
        @(negedge clk);
        check("bin_out", 32'(bin_out), 32'(e_bin));
        check("digit_err", 32'(digit_err), 32'(e_err));
        check("valid", 32'(valid), 32'(e_vld));
        check("frame_valid", 32'(frame_valid), 32'(e_fv));
        if (frame_valid) fv_count++;
    end

    initial begin
        reset = 1'b1; an = '1; sev = '1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Nothing displayed
        idle(50); #1;
        check("idle_bin", 32'(bin_out), 32'h0);
        check("idle_valid", 32'(valid), 32'h0);
        check("idle_fv_count", 32'(fv_count), 32'h0);

        // 3,A,7,F with exact publish latency on the last digit
        show(3, 3, 8); show(2, 10, 8); show(1, 7, 8);
        an = 4'b1110; sev = glyph[15];
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            check($sformatf("fv_latency_%0d", j), 32'(frame_valid), (j == 6) ? 32'h1 : 32'h0);
        end
        #1;
        check("scan_bin", 32'(bin_out), 32'h3A7F);
        check("scan_err", 32'(digit_err), 32'h0);
        check("scan_valid", 32'(valid), 32'h1);
        check("scan_fv_count", 32'(fv_count), 32'h1);

        // Digit 0 dwell too short, then adequate
        base = fv_count;
        show(3, 5, 8); show(2, 6, 8); show(1, 7, 8); show(0, 1, S - 1); idle(4); #1;
        check("short_no_frame", 32'(fv_count), 32'(base));
        check("short_bin_held", 32'(bin_out), 32'h3A7F);
        show(0, 1, 8); #1;
        check("short_then_frame", 32'(fv_count), 32'(base + 1));
        check("short_bin", 32'(bin_out), 32'h5671);

        // Blank digit 2
        show(3, 1, 8); show(2, 16, 8); show(1, 2, 8); show(0, 12, 8); #1;
        check("blank_bin", 32'(bin_out), 32'h102C);
        check("blank_err", 32'(digit_err), 32'h4);
        check("blank_fv_count", 32'(fv_count), 32'(base + 2));

        // Two digits lit at once never capture
        base = fv_count;
        show(3, 4, 8); show(2, 9, 8);
        an = 4'b1100; sev = glyph[14];
        repeat (20) @(negedge clk);
        show(1, 11, 8); #1;
        check("dual_no_frame", 32'(fv_count), 32'(base));
        show(0, 13, 8); #1;
        check("dual_then_frame", 32'(fv_count), 32'(base + 1));
        check("dual_bin", 32'(bin_out), 32'h49BD);
        check("dual_err", 32'(digit_err), 32'h0);

        // Reset mid-frame discards partial captures
        show(3, 1, 8); show(2, 2, 8); show(1, 3, 8);
        idle(1);
        reset = 1'b1;
        @(negedge clk); #1;
        check("rst_bin", 32'(bin_out), 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_err", 32'(digit_err), 32'h0);
        reset = 1'b0;
        base = fv_count;
        show(0, 4, 8); idle(10); #1;
        check("rst_no_frame", 32'(fv_count), 32'(base));
        check("rst_bin_zero", 32'(bin_out), 32'h0);
        show(0, 8, 8); show(3, 5, 8); show(2, 6, 8); show(1, 7, 8); #1;
        check("rescan_frame", 32'(fv_count), 32'(base + 1));
        check("rescan_bin", 32'(bin_out), 32'h5678);
        check("rescan_valid", 32'(valid), 32'h1);

        idle(4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
